edge_stream_framer: RTL and testbench

//  Downstream stage of the edge-detection AXI-stream top. Consumes the 8-bit edge-magnitude stream
//  and optionally binarizes it against a runtime threshold. Adds video framing: TUSER marks

---
 rtl/edge_stream_framer.sv | 231 +++++++++++++++++++++++
 tb/tb_edge_stream_framer.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_stream_framer.sv
// -----------------------------------------------------------------------------
// edge_stream_framer
//
// Final stage of the edge-detection AXI-stream pipeline. Takes the 8-bit edge
// magnitude stream and can binarize it against a runtime threshold. It also
// adds video framing so that a video DMA can consume the stream directly:
// TUSER marks start-of-frame and TLAST marks end-of-line. Edge pixels are
// counted per frame. The output register and one skid entry let the stage
// keep full throughput when the downstream applies backpressure.
//
// Ports
//   ACLK        clock, all logic on the rising edge
//   ARESETn     asynchronous active-low reset
//   TVALID_sub  input pixel valid
//   TDATA_sub   input edge magnitude (unsigned)
//   TREADY_sub  input ready (registered, low only while the skid entry is full)
//   TVALID_man  output pixel valid
//   TDATA_man   output pixel (binarized or pass-through)
//   TLAST_man   end-of-line flag on the last pixel of each line
//   TUSER_man   start-of-frame flag on pixel (0,0)
//   TREADY_man  downstream ready
//   BINARIZE    1: output is 8'hFF/8'h00 by threshold compare, 0: pass-through
//   THRESHOLD   binarize / edge threshold, unsigned
//   SOFT_CLR    synchronous flush of position counters, accumulator and buffers
//   FRAME_DONE  one-cycle pulse after the last pixel of a frame transfers out
//   EDGE_COUNT  pixels with input >= THRESHOLD in the last completed frame
// -----------------------------------------------------------------------------
module edge_stream_framer #(
    parameter int IMG_WIDTH  = 512,
    parameter int IMG_HEIGHT = 512,
    parameter int CNT_W      = 19
) (
    input  logic             ACLK,
    input  logic             ARESETn,
    input  logic             TVALID_sub,
    input  logic [7:0]       TDATA_sub,
    output logic             TREADY_sub,
    output logic             TVALID_man,
    output logic [7:0]       TDATA_man,
    output logic             TLAST_man,
    output logic             TUSER_man,
    input  logic             TREADY_man,
    input  logic             BINARIZE,
    input  logic [7:0]       THRESHOLD,
    input  logic             SOFT_CLR,
    output logic             FRAME_DONE,
    output logic [CNT_W-1:0] EDGE_COUNT
);

    localparam int COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

    // A buffered pixel: the processed byte plus the framing tags it was
    // given when it was accepted. eof rides along so FRAME_DONE can be
    // raised when that exact pixel leaves, not when it arrives.
    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       sof;
        logic       eof;
    } pix_t;

    // Binarization of one byte; the edge decision is computed once by the
    // caller because the edge counter needs it regardless of BINARIZE.
    function automatic logic [7:0] binarize(input logic [7:0] px,
                                            input logic       en,
                                            input logic       is_edge);
        logic [7:0] res;
        if (en) begin
            res = is_edge ? 8'hFF : 8'h00;
        end else begin
            res = px;
        end
        return res;
    endfunction

    // Position in the frame, edge accumulator and result register.
    logic [COL_W-1:0] col_q,  col_d;
    logic [ROW_W-1:0] row_q,  row_d;
    logic [CNT_W-1:0] acc_q,  acc_d;
    logic [CNT_W-1:0] ec_q,   ec_d;

    // Output register and skid entry.
    pix_t             out_q,  out_d;
    logic             out_vld_q, out_vld_d;
    pix_t             skid_q, skid_d;
    logic             skid_vld_q, skid_vld_d;

    logic             rdy_q,  rdy_d;
    logic             fd_q,   fd_d;

    logic             accept;
    logic             xfer;
    logic             is_edge;
    logic             at_last_col;
    logic             at_last_row;
    pix_t             in_pix;

    // ---- accept-side processing: tag and binarize the incoming byte ----
    always_comb begin
        accept      = TVALID_sub & rdy_q;
        xfer        = out_vld_q & TREADY_man;
        is_edge     = (TDATA_sub >= THRESHOLD);
        at_last_col = (col_q == COL_LAST);
        at_last_row = (row_q == ROW_LAST);

        in_pix      = '0;
        in_pix.data = binarize(TDATA_sub, BINARIZE, is_edge);
        in_pix.last = at_last_col;
        in_pix.sof  = (col_q == '0) && (row_q == '0);
        in_pix.eof  = at_last_col && at_last_row;
    end

    // ---- next-state: buffer movement, counters, frame statistics ----
    always_comb begin
        out_d      = out_q;
        out_vld_d  = out_vld_q;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;
        col_d      = col_q;
        row_d      = row_q;
        acc_d      = acc_q;
        ec_d       = ec_q;
        fd_d       = 1'b0;
        rdy_d      = rdy_q;

        if (SOFT_CLR) begin
            // Flush wins over anything that would have happened this edge;
            // the last completed frame's count stays visible.
            out_vld_d  = 1'b0;
            skid_vld_d = 1'b0;
            col_d      = '0;
            row_d      = '0;
            acc_d      = '0;
            rdy_d      = 1'b1;
        end else begin
            // Buffer movement. The skid can only be filled while the output
            // register is held, and TREADY_sub is low while it is full, so an
            // accept never coincides with a full skid.
            if (xfer) begin
                if (skid_vld_q) begin
                    out_d      = skid_q;
                    skid_vld_d = 1'b0;
                end else if (accept) begin
                    out_d      = in_pix;
                end else begin
                    out_vld_d  = 1'b0;
                end
            end else if (!out_vld_q) begin
                if (accept) begin
                    out_d     = in_pix;
                    out_vld_d = 1'b1;
                end
            end else if (accept) begin
                skid_d     = in_pix;
                skid_vld_d = 1'b1;
            end

            // Frame completion is reported when the eof pixel leaves.
            fd_d = xfer & out_q.eof;

            // Position and edge statistics advance on accept only.
            if (accept) begin
                if (at_last_col) begin
                    col_d = '0;
                    if (at_last_row) begin
                        row_d = '0;
                    end else begin
                        row_d = row_q + ROW_W'(1);
                    end
                end else begin
                    col_d = col_q + COL_W'(1);
                end

                if (in_pix.eof) begin
                    ec_d  = acc_q + CNT_W'(is_edge);
                    acc_d = '0;
                end else begin
                    acc_d = acc_q + CNT_W'(is_edge);
                end
            end

            // Ready is registered and mirrors skid occupancy.
            rdy_d = ~skid_vld_d;
        end
    end

    // ---- state registers ----
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            out_q      <= '0;
            out_vld_q  <= 1'b0;
            skid_vld_q <= 1'b0;
            col_q      <= '0;
            row_q      <= '0;
            acc_q      <= '0;
            ec_q       <= '0;
            fd_q       <= 1'b0;
            rdy_q      <= 1'b0;
        end else begin
            out_q      <= out_d;
            out_vld_q  <= out_vld_d;
            skid_vld_q <= skid_vld_d;
            col_q      <= col_d;
            row_q      <= row_d;
            acc_q      <= acc_d;
            ec_q       <= ec_d;
            fd_q       <= fd_d;
            rdy_q      <= rdy_d;
        end
    end

    // Skid payload is only meaningful while skid_vld_q is set, so it needs
    // no reset.
    always_ff @(posedge ACLK) begin
        skid_q <= skid_d;
    end

    // ---- outputs ----
    assign TREADY_sub = rdy_q;
    assign TVALID_man = out_vld_q;
    assign TDATA_man  = out_q.data;
    assign TLAST_man  = out_q.last;
    assign TUSER_man  = out_q.sof;
    assign FRAME_DONE = fd_q;
    assign EDGE_COUNT = ec_q;

endmodule

// File: tb/tb_edge_stream_framer.sv
// -----------------------------------------------------------------------------
// tb_edge_stream_framer
//
// Bench for edge_stream_framer with a 4x2 frame. A reference model tracks the
// pixels that should be in flight as a queue, derives each pixel's framing
// tags from its index within the frame, and keeps the expected frame count
// and FRAME_DONE pulse. Directed scenarios are followed by randomized traffic.
// -----------------------------------------------------------------------------
module tb_edge_stream_framer;

    localparam int W  = 4;
    localparam int H  = 2;
    localparam int CW = 8;

    logic          ACLK       = 1'b0;
    logic          ARESETn    = 1'b0;
    logic          TVALID_sub = 1'b0;
    logic [7:0]    TDATA_sub  = 8'h00;
    logic          TREADY_sub;
    logic          TVALID_man;
    logic [7:0]    TDATA_man;
    logic          TLAST_man;
    logic          TUSER_man;
    logic          TREADY_man = 1'b1;
    logic          BINARIZE   = 1'b0;
    logic [7:0]    THRESHOLD  = 8'h00;
    logic          SOFT_CLR   = 1'b0;
    logic          FRAME_DONE;
    logic [CW-1:0] EDGE_COUNT;

    edge_stream_framer #(
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H),
        .CNT_W     (CW)
    ) dut (
        .ACLK      (ACLK),
        .ARESETn   (ARESETn),
        .TVALID_sub(TVALID_sub),
        .TDATA_sub (TDATA_sub),
        .TREADY_sub(TREADY_sub),
        .TVALID_man(TVALID_man),
        .TDATA_man (TDATA_man),
        .TLAST_man (TLAST_man),
        .TUSER_man (TUSER_man),
        .TREADY_man(TREADY_man),
        .BINARIZE  (BINARIZE),
        .THRESHOLD (THRESHOLD),
        .SOFT_CLR  (SOFT_CLR),
        .FRAME_DONE(FRAME_DONE),
        .EDGE_COUNT(EDGE_COUNT)
    );

    always #5 ACLK = ~ACLK;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [7:0] data;
        logic       last;
        logic       user;
        logic       eof;
    } exp_t;

    exp_t q[$];
    int   pix_idx  = 0;
    int   acc_m    = 0;
    int   ec_m     = 0;
    bit   fd_m     = 1'b0;
    bit   rst_pend = 1'b1;
    int   fd_cnt   = 0;
    int   acc_cnt  = 0;
    bit   m_xfer;
    bit   m_acc;
    bit   m_edge;
    exp_t e;

    // All DUT signals are stable at the falling edge; what is seen here is
    // what the next rising edge will act on.
    always @(negedge ACLK) begin
        if (!ARESETn) begin
            chk("rst_tvalid", TVALID_man, 0);
            chk("rst_tready", TREADY_sub, 0);
            chk("rst_tdata",  TDATA_man, 0);
            chk("rst_tlast",  TLAST_man, 0);
            chk("rst_tuser",  TUSER_man, 0);
            chk("rst_frame_done", FRAME_DONE, 0);
            chk("rst_edge_count", EDGE_COUNT, 0);
            q.delete();
            pix_idx  = 0;
            acc_m    = 0;
            ec_m     = 0;
            fd_m     = 1'b0;
            rst_pend = 1'b1;
        end else begin
            chk("tvalid", TVALID_man, q.size() > 0);
            chk("tready", TREADY_sub, !rst_pend && q.size() < 2);
            chk("frame_done", FRAME_DONE, fd_m);
            chk("edge_count", EDGE_COUNT, ec_m);
            if (q.size() > 0 && TVALID_man) begin
                chk("tdata", TDATA_man, q[0].data);
                chk("tlast", TLAST_man, q[0].last);
                chk("tuser", TUSER_man, q[0].user);
            end
            if (FRAME_DONE) fd_cnt++;

            m_xfer = (q.size() > 0) && TREADY_man;
            m_acc  = TVALID_sub && !rst_pend && (q.size() < 2);

            if (SOFT_CLR) begin
                q.delete();
                pix_idx = 0;
                acc_m   = 0;
                fd_m    = 1'b0;
            end else begin
                fd_m = m_xfer ? q[0].eof : 1'b0;
                if (m_xfer) void'(q.pop_front());
                if (m_acc) begin
                    acc_cnt++;
                    m_edge = (TDATA_sub >= THRESHOLD);
                    e.data = BINARIZE ? (m_edge ? 8'hFF : 8'h00) : TDATA_sub;
                    e.last = (pix_idx % W) == W - 1;
                    e.user = (pix_idx == 0);
                    e.eof  = (pix_idx == W * H - 1);
                    q.push_back(e);
                    acc_m += int'(m_edge);
                    if (e.eof) begin
                        ec_m    = acc_m;
                        acc_m   = 0;
                        pix_idx = 0;
                    end else begin
                        pix_idx++;
                    end
                end
            end
            rst_pend = 1'b0;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge ACLK);
        #1;
    endtask

    task automatic send(input logic [7:0] d);
        int n = 0;
        TVALID_sub = 1'b1;
        TDATA_sub  = d;
        @(negedge ACLK);
        while (!TREADY_sub && n < 200) begin
            n++;
            @(negedge ACLK);
        end
        if (n >= 200) chk("send_timeout", TREADY_sub, 1);
        @(posedge ACLK);
        #1;
        TVALID_sub = 1'b0;
    endtask

    task automatic sclr();
        SOFT_CLR = 1'b1;
        cyc();
        SOFT_CLR = 1'b0;
    endtask

    int         f0;
    int         a0;
    int         n_edge;
    logic [7:0] v;
    bit         done;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_errors, n_checks);
        $fatal(1);
    end

    initial begin
        // 1: reset held with valid input; ready only after the first edge
        TVALID_sub = 1'b1;
        TDATA_sub  = 8'h55;
        repeat (3) cyc();
        ARESETn = 1'b1;
        @(negedge ACLK);
        #1;
        chk("t1_tready_before_edge", TREADY_sub, 0);
        cyc();
        chk("t1_tready_after_edge", TREADY_sub, 1);
        chk("t1_nothing_accepted", TVALID_man, 0);
        TVALID_sub = 1'b0;
        cyc();

        // 2: binarize threshold 3, inputs 0..7 back-to-back
        BINARIZE   = 1'b1;
        THRESHOLD  = 8'd3;
        TREADY_man = 1'b1;
        f0 = fd_cnt;
        for (int i = 0; i < 8; i++) send(8'(i));
        repeat (4) cyc();
        chk("t2_edge_count", EDGE_COUNT, 5);
        chk("t2_frame_done_pulses", fd_cnt - f0, 1);

        // 3: downstream stalled for 5 cycles with continuous input
        TREADY_man = 1'b0;
        TVALID_sub = 1'b1;
        a0 = acc_cnt;
        for (int i = 0; i < 5; i++) begin
            TDATA_sub = 8'($urandom);
            cyc();
        end
        chk("t3_stall_accepts", acc_cnt - a0, 2);
        chk("t3_stall_tready", TREADY_sub, 0);
        TREADY_man = 1'b1;
        cyc();
        chk("t3_tready_after_transfer", TREADY_sub, 1);
        TVALID_sub = 1'b0;
        repeat (4) cyc();
        sclr();

        // 4: pass-through with threshold 8'h80
        BINARIZE  = 1'b0;
        THRESHOLD = 8'h80;
        send(8'hA5); send(8'h03); send(8'hFF); send(8'h00);
        for (int i = 0; i < 4; i++) send(8'h00);
        repeat (4) cyc();
        chk("t4_edge_count", EDGE_COUNT, 2);

        // 5: soft clear with output stalled, then a fresh frame
        BINARIZE  = 1'b1;
        THRESHOLD = 8'h40;
        for (int i = 0; i < 3; i++) send(8'($urandom));
        TREADY_man = 1'b0;
        send(8'($urandom));
        sclr();
        @(negedge ACLK);
        #1;
        chk("t5_tvalid_after_clr", TVALID_man, 0);
        chk("t5_tready_after_clr", TREADY_sub, 1);
        cyc();
        TREADY_man = 1'b1;
        f0     = fd_cnt;
        n_edge = 0;
        for (int i = 0; i < 8; i++) begin
            v = 8'($urandom);
            if (v >= 8'h40) n_edge++;
            send(v);
        end
        repeat (4) cyc();
        chk("t5_frame_done_pulses", fd_cnt - f0, 1);
        chk("t5_edge_count", EDGE_COUNT, n_edge);

        // 6: random valid/ready over 3 frames
        f0   = fd_cnt;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 3 * W * H; i++) begin
                    while ($urandom_range(1) == 0) cyc();
                    THRESHOLD = 8'($urandom);
                    BINARIZE  = 1'($urandom);
                    send(8'($urandom));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    TREADY_man = 1'($urandom_range(1));
                    cyc();
                end
                TREADY_man = 1'b1;
            end
        join
        repeat (6) cyc();
        chk("t6_frame_done_pulses", fd_cnt - f0, 3);

        // 7: asynchronous reset in the middle of a frame
        for (int i = 0; i < 3; i++) send(8'($urandom));
        #2;
        ARESETn = 1'b0;
        #1;
        chk("t7_async_tvalid", TVALID_man, 0);
        chk("t7_async_tready", TREADY_sub, 0);
        repeat (2) cyc();
        ARESETn = 1'b1;
        BINARIZE  = 1'b0;
        THRESHOLD = 8'h10;
        f0     = fd_cnt;
        n_edge = 0;
        for (int i = 0; i < 8; i++) begin
            v = 8'($urandom);
            if (v >= 8'h10) n_edge++;
            send(v);
        end
        repeat (4) cyc();
        chk("t7_frame_done_pulses", fd_cnt - f0, 1);
        chk("t7_edge_count", EDGE_COUNT, n_edge);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
